// File: rtl/modbus_frame_timer.sv
// Modbus RTU receive-side baud prescaler and t1.5/t3.5 silence sequencer.
// Divisor changes are taken through a valid/ready handshake and applied on a prescaler wrap.
module modbus_frame_timer #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int T15_OS      = 264,
  parameter int T35_OS      = 616,
  parameter int SIL_W       = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             rx_activity,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_err,
  output logic             t35_pulse,
  output logic             frame_idle
);

  // state  | meaning
  // WAIT35 | waiting for t3.5 of silence before a frame may start
  // IDLE   | bus idle, next activity starts a frame
  // RX     | inside a frame, watching for t1.5 of silence
  // GAP    | frame ended, activity before t3.5 is an error
  localparam logic [1:0] S_WAIT35 = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_RX     = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [SIL_W-1:0] SIL_T15 = SIL_W'(T15_OS);
  localparam logic [SIL_W-1:0] SIL_T35 = SIL_W'(T35_OS);

  logic [DIV_W-1:0] div_q, div_d, pend_q, pend_d, presc_q, presc_d, div_m1;
  logic [3:0]       phase_q, phase_d;
  logic [SIL_W-1:0] sil_q, sil_d;
  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             os_q, os_d, bit_q, bit_d;
  logic             fs_q, fs_d, fe_q, fe_d, ferr_q, ferr_d, t35_q, t35_d;
  logic             idle_q, idle_d;
  logic             wrap, apply, accept;

  always_comb begin
    div_m1  = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    wrap    = (presc_q == div_m1);
    apply   = !ready_q && wrap;
    accept  = cfg_valid && ready_q;

    div_d   = div_q;
    pend_d  = pend_q;
    presc_d = presc_q;
    phase_d = phase_q;
    sil_d   = sil_q;
    state_d = state_q;
    ready_d = ready_q;
    os_d    = wrap;
    bit_d   = wrap && (phase_q == 4'hf) && !rx_activity;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ferr_d  = 1'b0;
    t35_d   = 1'b0;

    // Resync and divisor apply both restart the timebase; resync wins trivially since both clear.
    if (rx_activity || apply) begin
      presc_d = '0;
      phase_d = '0;
      sil_d   = '0;
    end else if (wrap) begin
      presc_d = '0;
      phase_d = phase_q + 4'd1;
      sil_d   = (sil_q == SIL_T35) ? sil_q : sil_q + SIL_W'(1);
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end

    if (apply) begin
      div_d   = pend_q;
      ready_d = 1'b1;
    end else if (accept) begin
      pend_d  = cfg_div;
      ready_d = 1'b0;
    end

    case (state_q)
      S_WAIT35: begin
        if (!rx_activity && sil_d == SIL_T35) begin
          t35_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (rx_activity) begin
          fs_d    = 1'b1;
          state_d = S_RX;
        end
      end
      S_RX: begin
        if (!rx_activity && sil_d == SIL_T15) begin
          fe_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      default: begin
        if (rx_activity) begin
          ferr_d  = 1'b1;
          state_d = S_WAIT35;
        end else if (sil_d == SIL_T35) begin
          t35_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase

    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q   <= DIV_W'(DEFAULT_DIV);
      pend_q  <= '0;
      presc_q <= '0;
      phase_q <= '0;
      sil_q   <= '0;
      state_q <= S_WAIT35;
      ready_q <= 1'b1;
      os_q    <= 1'b0;
      bit_q   <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ferr_q  <= 1'b0;
      t35_q   <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      sil_q   <= sil_d;
      state_q <= state_d;
      ready_q <= ready_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ferr_q  <= ferr_d;
      t35_q   <= t35_d;
      idle_q  <= idle_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign os_tick     = os_q;
  assign bit_tick    = bit_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign frame_err   = ferr_q;
  assign t35_pulse   = t35_q;
  assign frame_idle  = idle_q;

endmodule

// File: tb/tb_modbus_frame_timer.sv
// Bench for modbus_frame_timer: directed scenarios plus random traffic, every cycle compared
// against a tick/silence reference model.
module tb_modbus_frame_timer;
  localparam int DIV_W = 16;
  localparam int DEF   = 4;
  localparam int T15   = 3;
  localparam int T35   = 7;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_valid = 1'b0;
  logic             rx_activity = 1'b0;
  logic             cfg_ready, os_tick, bit_tick, frame_start, frame_end;
  logic             frame_err, t35_pulse, frame_idle;

  modbus_frame_timer #(
    .DIV_W(DIV_W), .DEFAULT_DIV(DEF), .T15_OS(T15), .T35_OS(T35), .SIL_W(16)
  ) dut (
    .clk_in(clk_in), .reset(reset), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .rx_activity(rx_activity), .os_tick(os_tick),
    .bit_tick(bit_tick), .frame_start(frame_start), .frame_end(frame_end),
    .frame_err(frame_err), .t35_pulse(t35_pulse), .frame_idle(frame_idle)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: ticks counted since the last timebase restart; silence and phase
  // both derive from that single count.
  typedef enum int {M_WAIT, M_IDLE, M_FRAME, M_GAP} mstate_e;
  mstate_e m_st;
  int m_div, m_pend, m_age, m_ticks;
  bit m_ready, e_os, e_bit, e_fs, e_fe, e_err, e_t35;

  task automatic model_reset();
    m_st = M_WAIT; m_div = DEF; m_pend = 0; m_age = 0; m_ticks = 0; m_ready = 1;
    {e_os, e_bit, e_fs, e_fe, e_err, e_t35} = '0;
  endtask

  task automatic model_step(input bit rx, input bit cv, input int cd);
    int eff, sil;
    bit wrap, apply;
    eff   = (m_div == 0) ? 1 : m_div;
    wrap  = (m_age % eff) == eff - 1;
    apply = !m_ready && wrap;
    e_os  = wrap;
    e_bit = wrap && (m_ticks % 16 == 15) && !rx;
    {e_fs, e_fe, e_err, e_t35} = '0;
    if (rx || apply) begin
      m_age = 0; m_ticks = 0;
    end else begin
      m_age++;
      if (wrap) m_ticks++;
    end
    if (apply) begin
      m_div = m_pend; m_ready = 1;
    end else if (cv && m_ready) begin
      m_pend = cd; m_ready = 0;
    end
    sil = (m_ticks > T35) ? T35 : m_ticks;
    case (m_st)
      M_WAIT:  if (!rx && sil == T35) begin e_t35 = 1; m_st = M_IDLE; end
      M_IDLE:  if (rx) begin e_fs = 1; m_st = M_FRAME; end
      M_FRAME: if (!rx && sil == T15) begin e_fe = 1; m_st = M_GAP; end
      default: begin
        if (rx) begin e_err = 1; m_st = M_WAIT; end
        else if (sil == T35) begin e_t35 = 1; m_st = M_IDLE; end
      end
    endcase
  endtask

  function automatic int outs_obs();
    return int'({cfg_ready, os_tick, bit_tick, frame_start, frame_end, frame_err,
                 t35_pulse, frame_idle});
  endfunction

  function automatic int outs_exp();
    return int'({m_ready, e_os, e_bit, e_fs, e_fe, e_err, e_t35, (m_st == M_IDLE)});
  endfunction

  task automatic cyc(input bit rx, input bit cv, input int cd);
    rx_activity = rx;
    cfg_valid   = cv;
    cfg_div     = DIV_W'(cd);
    @(posedge clk_in);
    model_step(rx, cv, cd);
    #1;
    chk("outs", outs_obs(), outs_exp());
    rx_activity = 1'b0;
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!frame_idle && n < 500) begin cyc(0, 0, 0); n++; end
    chk("idle_wait", frame_idle, 1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cfg_ready && n < 100) begin cyc(0, 0, 0); n++; end
    chk("ready_wait", cfg_ready, 1);
  endtask

  initial begin
    int n, k, gap1, gap2, cnt;
    bit rx, cv;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_outs", outs_obs(), 8'h80);
    reset = 1'b0;

    // Power-up: first tick, then t3.5 before the bus is declared idle.
    n = 0;
    do begin cyc(0, 0, 0); n++; end while (!os_tick && n < 50);
    chk("first_os", n, DEF);
    k = 1; n = 0;
    while (!t35_pulse && n < 200) begin cyc(0, 0, 0); n++; if (os_tick) k++; end
    chk("t35_at_os", k, T35);
    chk("idle_after_t35", frame_idle, 1);
    repeat (10) cyc(0, 0, 0);

    // Clean frame: start, end at t1.5, idle at t3.5.
    cyc(1, 0, 0);
    chk("frame_start", frame_start, 1);
    chk("idle_drop", frame_idle, 0);
    k = 0; n = 0;
    while (!frame_end && n < 100) begin cyc(0, 0, 0); n++; if (os_tick) k++; end
    chk("fe_os", k, T15);
    n = 0;
    while (!t35_pulse && n < 100) begin cyc(0, 0, 0); n++; if (os_tick) k++; end
    chk("t35_os", k, T35);

    // Activity in the t1.5..t3.5 gap.
    cyc(1, 0, 0);
    k = 0; n = 0;
    while (!frame_end && n < 100) begin cyc(0, 0, 0); n++; if (os_tick) k++; end
    while (k < 5 && n < 200) begin cyc(0, 0, 0); n++; if (os_tick) k++; end
    cyc(1, 0, 0);
    chk("frame_err", frame_err, 1);
    chk("err_not_idle", frame_idle, 0);
    k = 0; n = 0;
    while (!t35_pulse && n < 100) begin cyc(0, 0, 0); n++; if (os_tick) k++; end
    chk("rewait_os", k, T35);
    cyc(1, 0, 0);
    chk("restart", frame_start, 1);

    // Divisor change 4 -> 2 offered mid-period; second offer while pending is dropped.
    n = 0;
    while (!os_tick && n < 20) begin cyc(0, 0, 0); n++; end
    cyc(0, 0, 0);
    cyc(0, 1, 2);
    chk("cfg_rdy_low", cfg_ready, 0);
    cyc(0, 1, 6);
    n = 3;
    do begin cyc(0, 0, 0); n++; end while (!os_tick && n < 40);
    chk("apply_gap", n, DEF);
    chk("cfg_rdy_back", cfg_ready, 1);
    gap1 = 0;
    do begin cyc(0, 0, 0); gap1++; end while (!os_tick && gap1 < 40);
    gap2 = 0;
    do begin cyc(0, 0, 0); gap2++; end while (!os_tick && gap2 < 40);
    chk("new_gap1", gap1, 2);
    chk("new_gap2", gap2, 2);

    // Divisor 0 behaves as 1.
    cyc(0, 1, 0);
    wait_ready();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0);
      if (bit_tick) cnt++;
      if (i == 31) chk("os_every_cycle", os_tick, 1);
    end
    chk("bit_cnt32", cnt, 2);
    cyc(1, 0, 0);
    chk("os_with_rx", os_tick, 1);
    repeat (20) cyc(0, 0, 0);

    // Random traffic and divisor changes, alternating busy and quiet stretches.
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 200; i++) begin
        rx = (blk % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
        cv = ($urandom_range(0, 4) == 0);
        cyc(rx, cv, $urandom_range(0, 5));
      end
    end

    // Reset mid-frame with a divisor pending.
    wait_ready();
    cyc(0, 1, 3);
    wait_ready();
    wait_idle();
    cyc(1, 0, 0);
    cyc(0, 1, 2);
    chk("pending_before_rst", cfg_ready, 0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_outs", outs_obs(), 8'h80);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("rst_hold", outs_obs(), 8'h80);
    reset = 1'b0;
    n = 0;
    do begin cyc(0, 0, 0); n++; end while (!os_tick && n < 50);
    chk("rst_div", n, DEF);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
